pwm_breath_ctrl: RTL
====================

# pwm_breath_ctrl

Sequencer for a zPWM instance. It drives the PWM `en` and `cyc_duty` inputs and consumes the PWM `end_tick`. It ramps duty from 0 up to a programmable target and back down, holding at each end for a set number of PWM periods, to produce LED "breathing" and soft-start/soft-stop profiles. Every duty change lands on a PWM period boundary, so no period ever carries a partial duty value.

## Interface
Parameters:
- WIDTH, 20, width of the duty bus; must match the zPWM `pWIDTH`.
- PERIOD, 1000_000, PWM period in the zPWM count units; the target duty is clamped to this value.
- STEP, 10000, duty increment/decrement applied per PWM period.
- HOLD_PER, 4, number of PWM periods held at top and at bottom; must be ≥1.

Ports:
- clk  in  1  system clock, same clock as zPWM.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request to begin a profile; accepted only in IDLE.
- stop  in  1  abort request; honoured in any state.
- duty_max  in  WIDTH  ramp target; sampled on the cycle start is accepted.
- pwm_tick  in  1  connect to zPWM `end_tick`; marks the last cycle of a PWM period.
- pwm_en  out  1  connect to zPWM `en`.
- pwm_duty  out  WIDTH  connect to zPWM `cyc_duty`.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on normal profile completion.
- phase  out  3  current state code.

## Operation
- State codes: IDLE=0, RAMP_UP=1, HOLD_HIGH=2, RAMP_DOWN=3, HOLD_LOW=4. All outputs are registered.
- Reset values: state IDLE, pwm_en=0, pwm_duty=0, busy=0, done=0, phase=0, target=0, hold_cnt=0.
- **IDLE**
  - If start=1 and stop=0: go to RAMP_UP, set pwm_en=1 and pwm_duty=0.
  - Latch target = min(duty_max, PERIOD).
  - pwm_tick is ignored in IDLE.
- **RAMP_UP**, on pwm_tick:
  - If pwm_duty+STEP ≥ target: set pwm_duty=target, go to HOLD_HIGH, set hold_cnt=0.
  - Otherwise: pwm_duty += STEP.
  - Evaluate the sum at WIDTH+1 bits so it cannot overflow.
- **HOLD_HIGH**, on pwm_tick:
  - If hold_cnt==HOLD_PER-1: go to RAMP_DOWN.
  - Otherwise: hold_cnt++.
- **RAMP_DOWN**, on pwm_tick:
  - If pwm_duty ≤ STEP: set pwm_duty=0, go to HOLD_LOW, set hold_cnt=0.
  - Otherwise: pwm_duty -= STEP.
- **HOLD_LOW**, on pwm_tick:
  - If hold_cnt==HOLD_PER-1: end of profile; the next state depends on the configuration below.
  - Otherwise: hold_cnt++.
- **Stop**
  - In any non-IDLE state, stop=1 sends the block to IDLE on the next cycle with pwm_en=0 and pwm_duty=0.
  - No done pulse is generated.
  - stop has priority over pwm_tick and over start.
- **Boundary cases**
  - start while busy: ignored, and duty_max is not resampled.
  - target=0: the first RAMP_UP tick goes to HOLD_HIGH with duty 0.
  - target=PERIOD: the final ramp step clamps exactly to PERIOD.
  - Asynchronous reset mid-profile: all outputs return to their reset values immediately.

## Timing
- pwm_en rises and busy rises in the cycle after start is accepted.
- Every duty or state update takes effect in the cycle after pwm_tick, i.e. the first cycle of the next PWM period.
- done is high for exactly one cycle, in the same cycle that phase returns to 0.
- Profile length with no stop, measured in pwm_tick events:
  - ceil(target/STEP) to ramp up; 1 if target=0.
  - HOLD_PER at the top.
  - ceil(target/STEP) to ramp down; 1 if target=0.
  - HOLD_PER at the bottom.

## Configuration
- Macro: ZPWM_BREATH_REPEAT_EN.
- Defined: HOLD_LOW completion goes to RAMP_UP, with no done pulse and pwm_en kept at 1. The profile repeats with the latched target until stop is asserted.
- Undefined: HOLD_LOW completion goes to IDLE, drives pwm_en=0 and pulses done for one cycle.

## Test plan
Bench settings: WIDTH=8, PERIOD=100, STEP=25, HOLD_PER=2, and pwm_tick driven from a real zPWM instance.

1. Macro undefined, duty_max=60 + start → pwm_duty over successive ticks 0,25,50,60,60,60,35,10,0,0; phase sequence 1,2,3,4,0; done pulses once; pwm_en=0 afterwards.
2. duty_max=200 → target clamps to 100; ramp-up goes 0,25,50,75,100, then holds at 100.
3. stop asserted in RAMP_DOWN at duty=35 → next cycle phase=0, pwm_en=0, pwm_duty=0, done stays 0.
4. start re-pulsed with duty_max=10 while in HOLD_HIGH → ignored, target remains 60; start and stop asserted together in IDLE → stays IDLE.
5. Macro defined, duty_max=50 → after HOLD_LOW the block returns to phase 1 with no done pulse; a second profile is identical; stop ends it.
6. rst_n dropped while in RAMP_UP with duty=50 → all outputs immediately take their reset values; after release, pwm_tick alone does not start a profile.

Source files
------------

// File: rtl/pwm_breath_ctrl.sv
// pwm_breath_ctrl: duty-cycle sequencer for a zPWM instance.
// Ramps duty from 0 to a latched target, holds, ramps back to 0, holds,
// then finishes. Every duty/state change is taken on pwm_tick (the last
// cycle of a PWM period), so each PWM period carries exactly one duty value.
// Optional build macro: ZPWM_BREATH_REPEAT_EN -- when defined the profile
// loops back to RAMP_UP after the low hold instead of returning to IDLE.
module pwm_breath_ctrl #(
   parameter int WIDTH    = 20,
   parameter int PERIOD   = 1000_000,
   parameter int STEP     = 10000,
   parameter int HOLD_PER = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic [WIDTH-1:0] duty_max,
   input  logic             pwm_tick,
   output logic             pwm_en,
   output logic [WIDTH-1:0] pwm_duty,
   output logic             busy,
   output logic             done,
   output logic [2:0]       phase
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RAMP_UP   = 3'd1,
      HOLD_HIGH = 3'd2,
      RAMP_DOWN = 3'd3,
      HOLD_LOW  = 3'd4
   } state_t;

   // Hold counter only needs to reach HOLD_PER-1; keep at least one bit.
   localparam int HCW = (HOLD_PER > 1) ? $clog2(HOLD_PER) : 1;

   // Arithmetic is done one bit wider than the duty bus so the ramp-up sum
   // and the clamp comparison can never wrap.
   localparam logic [WIDTH:0]   PERIOD_W  = (WIDTH+1)'(PERIOD);
   localparam logic [WIDTH:0]   STEP_W    = (WIDTH+1)'(STEP);
   localparam logic [HCW-1:0]   HOLD_LAST = HCW'(HOLD_PER - 1);

   state_t           state_reg;
   logic [WIDTH-1:0] target_reg;
   logic [HCW-1:0]   hold_cnt_reg;

   logic [WIDTH:0]   duty_up_sum;
   logic             up_reach;
   logic             down_reach;
   logic [WIDTH-1:0] duty_dec;
   logic [WIDTH-1:0] target_clamped;
   logic             hold_last;

   // Ramp arithmetic and target clamp, evaluated from the current registers.
   always_comb begin
      duty_up_sum    = {1'b0, pwm_duty} + STEP_W;
      up_reach       = (duty_up_sum >= {1'b0, target_reg});
      down_reach     = ({1'b0, pwm_duty} <= STEP_W);
      // Only used when pwm_duty > STEP, so the subtraction cannot underflow.
      duty_dec       = pwm_duty - STEP_W[WIDTH-1:0];
      target_clamped = ({1'b0, duty_max} > PERIOD_W) ? PERIOD_W[WIDTH-1:0] : duty_max;
      hold_last      = (hold_cnt_reg == HOLD_LAST);
   end

   // Profile sequencer: state, latched target, hold counter and all outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         target_reg   <= '0;
         hold_cnt_reg <= '0;
         pwm_en       <= 1'b0;
         pwm_duty     <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state_reg != IDLE && stop) begin
            // Abort outranks both pwm_tick and start; no completion pulse.
            state_reg <= IDLE;
            pwm_en    <= 1'b0;
            pwm_duty  <= '0;
            busy      <= 1'b0;
         end else begin
            case (state_reg)
               IDLE: begin
                  // pwm_tick is irrelevant here; only an uncontested start begins.
                  if (start && !stop) begin
                     state_reg  <= RAMP_UP;
                     target_reg <= target_clamped;
                     pwm_en     <= 1'b1;
                     pwm_duty   <= '0;
                     busy       <= 1'b1;
                  end
               end
               RAMP_UP: begin
                  if (pwm_tick) begin
                     if (up_reach) begin
                        pwm_duty     <= target_reg;
                        state_reg    <= HOLD_HIGH;
                        hold_cnt_reg <= '0;
                     end else begin
                        pwm_duty <= duty_up_sum[WIDTH-1:0];
                     end
                  end
               end
               HOLD_HIGH: begin
                  if (pwm_tick) begin
                     if (hold_last) begin
                        state_reg <= RAMP_DOWN;
                     end else begin
                        hold_cnt_reg <= hold_cnt_reg + HCW'(1);
                     end
                  end
               end
               RAMP_DOWN: begin
                  if (pwm_tick) begin
                     if (down_reach) begin
                        pwm_duty     <= '0;
                        state_reg    <= HOLD_LOW;
                        hold_cnt_reg <= '0;
                     end else begin
                        pwm_duty <= duty_dec;
                     end
                  end
               end
               HOLD_LOW: begin
                  if (pwm_tick) begin
                     if (hold_last) begin
`ifdef ZPWM_BREATH_REPEAT_EN
                        // Loop with the same latched target; output stays enabled.
                        state_reg <= RAMP_UP;
`else
                        state_reg <= IDLE;
                        pwm_en    <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
`endif
                     end else begin
                        hold_cnt_reg <= hold_cnt_reg + HCW'(1);
                     end
                  end
               end
               default: begin
                  state_reg <= IDLE;
                  pwm_en    <= 1'b0;
                  pwm_duty  <= '0;
                  busy      <= 1'b0;
               end
            endcase
         end
      end
   end

   // The state register doubles as the phase code.
   assign phase = state_reg;

endmodule
